// File: rtl/pid_drive_seq.sv
// pid_drive_seq: sample-strobe decimator, pedaling detection FSM and soft-start drive limiter for the PID loop
module pid_drive_seq #(
  parameter int FAST_SIM  = 0,
  parameter int DEC_W     = 15,
  parameter int TIMEOUT   = 8,
  parameter int SPIN_CNT  = 2,
  parameter int RAMP_STEP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cadence_vld,
  input  logic        brake,
  input  logic [11:0] pid_drv,
  output logic        smpl_strb,
  output logic        not_pedaling,
  output logic [11:0] drv_mag,
  output logic [1:0]  seq_state
);
  localparam int EW = FAST_SIM != 0 ? 6 : DEC_W;
  typedef enum logic [1:0] {IDLE = 2'd0, SPINUP = 2'd1, RAMP = 2'd2, RUN = 2'd3} state_t;
  state_t        state_q;
  logic [EW-1:0] dec_q;
  logic [7:0]    to_q;
  logic [3:0]    spin_q;
  logic [11:0]   lim_q;
  logic [11:0]   drv_q;
  logic [12:0]   lim_sum;
  logic [4:0]    spin_nx;
  logic          timed_out;
  assign smpl_strb    = &dec_q;
  assign timed_out    = to_q == 8'(TIMEOUT);
  assign lim_sum      = {1'b0, lim_q} + 13'(RAMP_STEP);
  assign spin_nx      = {1'b0, spin_q} + 5'd1;
  assign not_pedaling = state_q == IDLE || state_q == SPINUP;
  assign drv_mag      = drv_q;
  assign seq_state    = state_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q   <= '0;
      to_q    <= '0;
      spin_q  <= '0;
      lim_q   <= '0;
      drv_q   <= '0;
      state_q <= IDLE;
    end else begin
      dec_q <= dec_q + EW'(1);
      to_q  <= cadence_vld ? 8'd0 : (smpl_strb && !timed_out) ? to_q + 8'd1 : to_q;
      drv_q <= state_q == RUN ? pid_drv : state_q == RAMP ? (pid_drv < lim_q ? pid_drv : lim_q) : 12'd0;
      if (brake || (state_q != IDLE && timed_out)) begin
        state_q <= IDLE;
        spin_q  <= '0;
        lim_q   <= '0;
      end else begin
        case (state_q)
          IDLE: if (cadence_vld) begin
            state_q <= SPINUP;
            spin_q  <= 4'd1;
          end
          SPINUP: if (cadence_vld) begin
            spin_q <= spin_nx[3:0];
            if (spin_nx >= 5'(SPIN_CNT)) begin
              state_q <= RAMP;
              lim_q   <= '0;
            end
          end
          RAMP: if (smpl_strb) begin
            if (lim_q == 12'hFFF) state_q <= RUN;
            lim_q <= lim_sum[12] ? 12'hFFF : lim_sum[11:0];
          end
          RUN: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pid_drive_seq.sv
// tb_pid_drive_seq: randomized scoreboard bench for pid_drive_seq against a behavioural model
module tb_pid_drive_seq;
  logic        clk = 1'b0;
  logic        rst, cad, brk;
  logic [11:0] pid;
  logic        smpl_strb, not_pedaling;
  logic [11:0] drv_mag;
  logic [1:0]  seq_state;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_cyc, m_to, m_st, m_spin, m_lim, m_drv;
  logic [15:0] exp_q[$];
  always #5 clk = ~clk;
  pid_drive_seq #(.FAST_SIM(1)) dut (
    .clk(clk), .rst(rst), .cadence_vld(cad), .brake(brk), .pid_drv(pid),
    .smpl_strb(smpl_strb), .not_pedaling(not_pedaling), .drv_mag(drv_mag), .seq_state(seq_state)
  );
  initial forever begin
    bit strb, tout;
    @(posedge clk);
    if (rst) begin
      m_cyc = 0; m_to = 0; m_st = 0; m_spin = 0; m_lim = 0; m_drv = 0;
    end else begin
      strb  = (m_cyc % 64) == 63;
      tout  = m_to == 8;
      m_drv = m_st == 3 ? int'(pid) : m_st == 2 ? (int'(pid) < m_lim ? int'(pid) : m_lim) : 0;
      if (brk || (m_st != 0 && tout)) begin
        m_st = 0; m_spin = 0; m_lim = 0;
      end else if (m_st == 0 && cad) begin
        m_st = 1; m_spin = 1;
      end else if (m_st == 1 && cad) begin
        m_spin++;
        if (m_spin >= 2) begin m_st = 2; m_lim = 0; end
      end else if (m_st == 2 && strb) begin
        if (m_lim == 4095) m_st = 3;
        m_lim = m_lim + 16 > 4095 ? 4095 : m_lim + 16;
      end
      m_to = cad ? 0 : strb ? (m_to < 8 ? m_to + 1 : 8) : m_to;
      m_cyc++;
    end
    exp_q.push_back({(m_cyc % 64) == 63, m_st < 2, 12'(m_drv), 2'(m_st)});
  end
  initial forever begin
    logic [15:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({smpl_strb, not_pedaling, drv_mag, seq_state} !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t got strb=%b np=%b drv=%h st=%0d exp strb=%b np=%b drv=%h st=%0d",
                 $time, smpl_strb, not_pedaling, drv_mag, seq_state, e[15], e[14], e[13:2], e[1:0]);
      end
    end
  end
  task automatic tick(input logic c, input logic b, input logic r, input logic [11:0] p);
    cad = c; brk = b; rst = r; pid = p;
    @(posedge clk);
    #1;
  endtask
  task automatic check_state(input string name, input logic [1:0] want);
    n_cmp++;
    if (seq_state !== want) begin
      n_bad++;
      $display("FAIL %s got state=%0d exp state=%0d", name, seq_state, want);
    end
  endtask
  task automatic spinup(input logic [11:0] p);
    tick(1, 0, 0, p);
    repeat (19) tick(0, 0, 0, p);
    tick(1, 0, 0, p);
  endtask
  task automatic ride(input int lim_goal, input int budget, input bit rnd);
    int gap = 0;
    for (int i = 0; i < budget && !(lim_goal < 0 ? m_st == 3 : (m_st == 2 && m_lim == lim_goal)); i++) begin
      if (gap == 0) gap = $urandom_range(20, 400);
      gap--;
      tick(gap == 0, 0, 0, rnd ? 12'($urandom_range(0, 4095)) : 12'h800);
    end
  endtask
  initial begin
    int k;
    cad = 0; brk = 0; rst = 1; pid = 0;
    repeat (3) tick(0, 0, 1, 12'h800);
    repeat (200) tick(0, 0, 0, 12'h800);
    spinup(12'h800);
    ride(-1, 30000, 0);
    check_state("reach_run", 2'd3);
    k = 0;
    while (k < 700 && !(m_to == 7 && (m_cyc % 64) == 63)) begin
      tick(0, 0, 0, 12'h800);
      k++;
    end
    tick(1, 0, 0, 12'h800);
    repeat (100) tick(0, 0, 0, 12'h800);
    check_state("coincident_clear", 2'd3);
    k = 0;
    while (k < 700 && m_st != 0) begin
      tick(0, 0, 0, 12'($urandom_range(0, 4095)));
      k++;
    end
    check_state("timeout_idle", 2'd0);
    repeat (5) tick(0, 0, 0, 12'hFFF);
    spinup(12'hFFF);
    ride(-1, 30000, 1);
    check_state("reach_run2", 2'd3);
    tick(0, 1, 0, 12'hFFF);
    check_state("brake_idle", 2'd0);
    for (int i = 0; i < 60; i++) tick(i % 10 == 0, 1, 0, 12'hFFF);
    check_state("brake_held", 2'd0);
    tick(0, 0, 0, 12'hFFF);
    spinup(12'hFFF);
    ride(12'h300, 8000, 1);
    check_state("mid_ramp", 2'd2);
    tick(0, 0, 1, 12'hFFF);
    check_state("reset_mid_ramp", 2'd0);
    repeat (70) tick(0, 0, 0, 12'hFFF);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 1999) == 0,
           12'($urandom_range(0, 4095)));
    repeat (3) tick(0, 0, 0, 12'h000);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
